// File: rtl/mem_arbiter_if.sv
// Request, response and shared-bus signals between the two CPU ports, the arbiter and the bus.
// The arbiter takes the master view; the environment (cores and slave) takes the slave view.
interface mem_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;

  logic        mem_req_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_sel_i;
  logic        mem_ack_o;
  logic [31:0] mem_rdata_o;

  logic        bus_ce_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;

  logic [5:0]  stall_o;
  logic        err_o;

  modport master (
    input  if_req_i, if_addr_i,
    output if_ack_o, if_rdata_o,
    input  mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_sel_i,
    output mem_ack_o, mem_rdata_o,
    output bus_ce_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o,
    input  bus_rdata_i, bus_ack_i,
    output stall_o, err_o
  );

  modport slave (
    output if_req_i, if_addr_i,
    input  if_ack_o, if_rdata_o,
    output mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_sel_i,
    input  mem_ack_o, mem_rdata_o,
    input  bus_ce_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o,
    output bus_rdata_i, bus_ack_i,
    input  stall_o, err_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data access onto a single shared bus, with alternating
// priority on contention, a per-transfer wait timeout and a pipeline stall vector.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.master arb
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] D_XFER = 2'b01;
  localparam logic [1:0] I_XFER = 2'b10;

  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        last_data_q, last_data_d;

  logic        bus_ce_q, bus_ce_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_sel_q, bus_sel_d;

  logic        if_ack_q, if_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        mem_ack_q, mem_ack_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        err_q, err_d;

  logic        grant_data;
  logic        grant_inst;
  logic        in_xfer;
  logic        timed_out;
  logic        done;
  logic [31:0] done_rdata;
  logic [5:0]  stall;

  always_comb begin
    // On contention, data wins unless data also won the last completed grant.
    grant_data = arb.mem_req_i & (~arb.if_req_i | ~last_data_q);
    grant_inst = arb.if_req_i & ~grant_data;
    in_xfer    = (state_q == D_XFER) | (state_q == I_XFER);
    timed_out  = in_xfer & ~arb.bus_ack_i & (wait_q == WaitLast);
    done       = in_xfer & (arb.bus_ack_i | timed_out);
    // Aborted transfers and data writes return zero.
    done_rdata = (timed_out | ((state_q == D_XFER) & bus_we_q)) ? 32'h0 : arb.bus_rdata_i;
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    last_data_d = last_data_q;
    bus_ce_d    = bus_ce_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_sel_d   = bus_sel_q;
    if_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_ack_d   = 1'b0;
    mem_rdata_d = mem_rdata_q;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d     = D_XFER;
          wait_d      = 8'd0;
          bus_ce_d    = 1'b1;
          bus_we_d    = arb.mem_we_i;
          bus_addr_d  = arb.mem_addr_i;
          bus_wdata_d = arb.mem_wdata_i;
          bus_sel_d   = arb.mem_sel_i;
        end else if (grant_inst) begin
          state_d     = I_XFER;
          wait_d      = 8'd0;
          bus_ce_d    = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = arb.if_addr_i;
          bus_wdata_d = 32'h0;
          bus_sel_d   = 4'b1111;
        end
      end

      D_XFER, I_XFER: begin
        if (done) begin
          state_d     = IDLE;
          last_data_d = (state_q == D_XFER);
          bus_ce_d    = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = 32'h0;
          bus_wdata_d = 32'h0;
          bus_sel_d   = 4'b0000;
          err_d       = timed_out;
          if (state_q == D_XFER) begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = done_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = done_rdata;
          end
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      default: begin
        state_d     = IDLE;
        wait_d      = 8'd0;
        bus_ce_d    = 1'b0;
        bus_we_d    = 1'b0;
        bus_addr_d  = 32'h0;
        bus_wdata_d = 32'h0;
        bus_sel_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_q      <= 8'd0;
      last_data_q <= 1'b0;
      bus_ce_q    <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      bus_sel_q   <= 4'b0000;
      if_ack_q    <= 1'b0;
      if_rdata_q  <= 32'h0;
      mem_ack_q   <= 1'b0;
      mem_rdata_q <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      last_data_q <= last_data_d;
      bus_ce_q    <= bus_ce_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_sel_q   <= bus_sel_d;
      if_ack_q    <= if_ack_d;
      if_rdata_q  <= if_rdata_d;
      mem_ack_q   <= mem_ack_d;
      mem_rdata_q <= mem_rdata_d;
      err_q       <= err_d;
    end
  end

  // Data stalls the whole front of the pipe; a fetch miss only stalls pc/if/id.
  always_comb begin
    if (arb.mem_req_i & ~mem_ack_q) begin
      stall = 6'b011111;
    end else if (arb.if_req_i & ~if_ack_q) begin
      stall = 6'b000111;
    end else begin
      stall = 6'b000000;
    end
  end

  assign arb.bus_ce_o    = bus_ce_q;
  assign arb.bus_we_o    = bus_we_q;
  assign arb.bus_addr_o  = bus_addr_q;
  assign arb.bus_wdata_o = bus_wdata_q;
  assign arb.bus_sel_o   = bus_sel_q;
  assign arb.if_ack_o    = if_ack_q;
  assign arb.if_rdata_o  = if_rdata_q;
  assign arb.mem_ack_o   = mem_ack_q;
  assign arb.mem_rdata_o = mem_rdata_q;
  assign arb.err_o       = err_q;
  assign arb.stall_o     = stall;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of grant order, bus occupancy and responses.
module tb_mem_arbiter;
  localparam int unsigned TO = 16;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  bit   exp_last_data;
  logic [31:0] exp_if_rd;
  logic [31:0] exp_mem_rd;

  mem_arbiter_if arb ();

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .arb (arb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          wait_n;
    int          ce_n;
    bit          stable;
    bit          early;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [5:0]  stall_busy;
    logic        if_ack;
    logic        mem_ack;
    logic        err;
    logic [31:0] if_rd;
    logic [31:0] mem_rd;
    logic [5:0]  stall_done;
  } obs_t;

  // Bus slave: acks in bus cycle `lat` (0-based) and records what the arbiter did.
  task automatic serve(input int lat, input logic [31:0] rd, output obs_t o);
    o.wait_n = 0; o.ce_n = 0; o.stable = 1'b1; o.early = 1'b0;
    while (arb.bus_ce_o !== 1'b1 && o.wait_n < 50) begin
      @(negedge clk);
      o.wait_n++;
    end
    o.we = arb.bus_we_o; o.addr = arb.bus_addr_o; o.wdata = arb.bus_wdata_o;
    o.sel = arb.bus_sel_o; o.stall_busy = arb.stall_o;
    while (arb.bus_ce_o === 1'b1 && o.ce_n < 300) begin
      if ({arb.bus_we_o, arb.bus_addr_o, arb.bus_wdata_o, arb.bus_sel_o} !==
          {o.we, o.addr, o.wdata, o.sel}) o.stable = 1'b0;
      if (arb.if_ack_o | arb.mem_ack_o | arb.err_o) o.early = 1'b1;
      arb.bus_ack_i   = (o.ce_n == lat);
      arb.bus_rdata_i = (o.ce_n == lat) ? rd : $urandom;
      o.ce_n++;
      @(negedge clk);
    end
    arb.bus_ack_i   = 1'b0;
    arb.bus_rdata_i = $urandom;
    o.if_ack = arb.if_ack_o; o.mem_ack = arb.mem_ack_o; o.err = arb.err_o;
    o.if_rd = arb.if_rdata_o; o.mem_rd = arb.mem_rdata_o; o.stall_done = arb.stall_o;
  endtask

  task automatic set_data(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    arb.mem_req_i = 1'b1; arb.mem_we_i = we; arb.mem_addr_i = a;
    arb.mem_wdata_i = d; arb.mem_sel_i = s;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_data(1'b0, 32'h0000_0040, 32'h1234_5678, 4'b0011);
    arb.bus_ack_i = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({arb.bus_ce_o, arb.bus_we_o, arb.bus_addr_o, arb.bus_wdata_o, arb.bus_sel_o} !== 70'h0) begin
      n_bad++;
      $display("FAIL reset_bus: got ce=%b addr=%h, want all zero", arb.bus_ce_o, arb.bus_addr_o);
    end
    n_cmp++;
    if ({arb.if_ack_o, arb.mem_ack_o, arb.err_o, arb.if_rdata_o, arb.mem_rdata_o} !== 67'h0) begin
      n_bad++;
      $display("FAIL reset_resp: got acks=%b%b err=%b, want zero", arb.if_ack_o, arb.mem_ack_o,
               arb.err_o);
    end
    n_cmp++;
    if (arb.stall_o !== 6'b011111) begin
      n_bad++;
      $display("FAIL reset_stall: got %b want 011111", arb.stall_o);
    end
    @(negedge clk);
    rst = 1'b0;
    arb.bus_ack_i = 1'b0;
    exp_last_data = 1'b0; exp_if_rd = 32'h0; exp_mem_rd = 32'h0;
    begin
      obs_t o;
      serve(2, 32'hA5A5_0001, o);
      n_cmp++;
      if ({o.wait_n, o.ce_n, o.addr, o.sel} !== {32'd1, 32'd3, 32'h0000_0040, 4'b0011}) begin
        n_bad++;
        $display("FAIL reset_release: got wait=%0d ce=%0d addr=%h, want 1 3 00000040",
                 o.wait_n, o.ce_n, o.addr);
      end
      n_cmp++;
      if ({o.mem_ack, o.err, o.mem_rd} !== {2'b10, 32'hA5A5_0001}) begin
        n_bad++;
        $display("FAIL reset_first_xfer: got ack=%b err=%b rd=%h", o.mem_ack, o.err, o.mem_rd);
      end
    end
    exp_last_data = 1'b1; exp_mem_rd = 32'hA5A5_0001;
    arb.mem_req_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_idle_ack();
    arb.bus_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      arb.bus_rdata_i = $urandom;
      @(negedge clk);
      n_cmp++;
      if ({arb.bus_ce_o, arb.if_ack_o, arb.mem_ack_o, arb.err_o, arb.mem_rdata_o} !==
          {4'b0000, exp_mem_rd}) begin
        n_bad++;
        $display("FAIL idle_ack_ignored: got ce=%b acks=%b%b err=%b rd=%h", arb.bus_ce_o,
                 arb.if_ack_o, arb.mem_ack_o, arb.err_o, arb.mem_rdata_o);
      end
    end
    arb.bus_ack_i = 1'b0;
  endtask

  task automatic test_fetch_only();
    obs_t o;
    arb.if_req_i = 1'b1; arb.if_addr_i = 32'h0000_0100;
    #1;
    n_cmp++;
    if (arb.stall_o !== 6'b000111) begin
      n_bad++;
      $display("FAIL fetch_stall_req: got %b want 000111", arb.stall_o);
    end
    serve(0, 32'h0000_0013, o);
    n_cmp++;
    if ({o.wait_n, o.ce_n, o.we, o.addr, o.sel, o.stall_busy, o.stable, o.early} !==
        {32'd1, 32'd1, 1'b0, 32'h0000_0100, 4'b1111, 6'b000111, 2'b10}) begin
      n_bad++;
      $display("FAIL fetch_bus: got wait=%0d ce=%0d we=%b addr=%h sel=%b stall=%b",
               o.wait_n, o.ce_n, o.we, o.addr, o.sel, o.stall_busy);
    end
    n_cmp++;
    if ({o.if_ack, o.mem_ack, o.err, o.if_rd, o.stall_done} !==
        {3'b100, 32'h0000_0013, 6'b000000}) begin
      n_bad++;
      $display("FAIL fetch_ack: got ack=%b rd=%h stall=%b, want 1 00000013 000000", o.if_ack,
               o.if_rd, o.stall_done);
    end
    exp_last_data = 1'b0; exp_if_rd = 32'h0000_0013;
    arb.if_req_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({arb.if_ack_o, arb.if_rdata_o, arb.bus_ce_o} !== {1'b0, exp_if_rd, 1'b0}) begin
      n_bad++;
      $display("FAIL fetch_hold: got ack=%b rd=%h ce=%b", arb.if_ack_o, arb.if_rdata_o,
               arb.bus_ce_o);
    end
  endtask

  task automatic test_simultaneous();
    obs_t o;
    // Previous grant was a fetch, so data goes first.
    set_data(1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'b1111);
    arb.if_req_i = 1'b1; arb.if_addr_i = 32'h0000_0300;
    serve(0, 32'h1111_2222, o);
    n_cmp++;
    if ({o.we, o.addr, o.wdata, o.sel, o.mem_ack, o.if_ack, o.mem_rd} !==
        {1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'b1111, 2'b10, 32'h0}) begin
      n_bad++;
      $display("FAIL simul_data_first: got we=%b addr=%h wdata=%h ack=%b%b rd=%h", o.we,
               o.addr, o.wdata, o.mem_ack, o.if_ack, o.mem_rd);
    end
    arb.mem_req_i = 1'b0;
    serve(1, 32'h0000_0093, o);
    n_cmp++;
    if ({o.wait_n, o.we, o.addr, o.if_ack, o.mem_ack, o.if_rd} !==
        {32'd1, 1'b0, 32'h0000_0300, 2'b10, 32'h0000_0093}) begin
      n_bad++;
      $display("FAIL simul_fetch_follows: got wait=%0d addr=%h ack=%b rd=%h", o.wait_n, o.addr,
               o.if_ack, o.if_rd);
    end
    arb.if_req_i = 1'b0;
    // A lone data read makes data the last grant; the next pair must then favour the fetch.
    set_data(1'b0, 32'h0000_0400, 32'h0, 4'b0001);
    serve(0, 32'h0000_00FF, o);
    arb.mem_req_i = 1'b0;
    @(negedge clk);
    set_data(1'b0, 32'h0000_0500, 32'h0, 4'b1100);
    arb.if_req_i = 1'b1; arb.if_addr_i = 32'h0000_0600;
    serve(0, 32'h0000_0033, o);
    n_cmp++;
    if ({o.addr, o.if_ack, o.mem_ack, o.if_rd, o.stall_busy, o.stall_done} !==
        {32'h0000_0600, 2'b10, 32'h0000_0033, 6'b011111, 6'b011111}) begin
      n_bad++;
      $display("FAIL simul_fetch_first: got addr=%h ack=%b%b stall=%b/%b", o.addr, o.if_ack,
               o.mem_ack, o.stall_busy, o.stall_done);
    end
    arb.if_req_i = 1'b0;
    serve(0, 32'h0000_0044, o);
    n_cmp++;
    if ({o.addr, o.mem_ack, o.mem_rd} !== {32'h0000_0500, 1'b1, 32'h0000_0044}) begin
      n_bad++;
      $display("FAIL simul_data_second: got addr=%h ack=%b rd=%h", o.addr, o.mem_ack, o.mem_rd);
    end
    arb.mem_req_i = 1'b0;
    exp_last_data = 1'b1; exp_if_rd = 32'h0000_0033; exp_mem_rd = 32'h0000_0044;
    @(negedge clk);
  endtask

  task automatic test_slave_latency(input string name, input int lat, input logic [31:0] rd);
    obs_t o;
    bit tmo;
    tmo = (lat >= int'(TO));
    set_data(1'b0, 32'h0000_0800, 32'h0, 4'b1111);
    serve(lat, rd, o);
    n_cmp++;
    if ({o.ce_n, o.stable, o.early} !== {tmo ? int'(TO) : lat + 1, 2'b10}) begin
      n_bad++;
      $display("FAIL %s_bus: got ce_cycles=%0d stable=%b early=%b", name, o.ce_n, o.stable,
               o.early);
    end
    n_cmp++;
    if ({o.mem_ack, o.err, o.mem_rd} !== {1'b1, tmo, tmo ? 32'h0 : rd}) begin
      n_bad++;
      $display("FAIL %s_resp: got ack=%b err=%b rd=%h, want 1 %b %h", name, o.mem_ack, o.err,
               o.mem_rd, tmo, tmo ? 32'h0 : rd);
    end
    arb.mem_req_i = 1'b0;
    exp_last_data = 1'b1; exp_mem_rd = tmo ? 32'h0 : rd;
    @(negedge clk);
    n_cmp++;
    if ({arb.mem_ack_o, arb.err_o, arb.mem_rdata_o} !== {2'b00, exp_mem_rd}) begin
      n_bad++;
      $display("FAIL %s_single_pulse: got ack=%b err=%b rd=%h", name, arb.mem_ack_o, arb.err_o,
               arb.mem_rdata_o);
    end
  endtask

  task automatic test_reset_mid_xfer();
    obs_t o;
    int n;
    set_data(1'b0, 32'h0000_0900, 32'h0, 4'b1111);
    n = 0;
    while (arb.bus_ce_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({arb.bus_ce_o, arb.bus_addr_o, arb.bus_sel_o} !== 37'h0) begin
      n_bad++;
      $display("FAIL rst_mid_ce: got ce=%b addr=%h, want 0 00000000", arb.bus_ce_o,
               arb.bus_addr_o);
    end
    @(negedge clk);
    rst = 1'b0;
    arb.mem_req_i = 1'b0;
    exp_last_data = 1'b0; exp_if_rd = 32'h0; exp_mem_rd = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({arb.bus_ce_o, arb.mem_ack_o, arb.if_ack_o, arb.err_o} !== 4'b0000) begin
        n_bad++;
        $display("FAIL rst_mid_quiet: got ce=%b acks=%b%b err=%b", arb.bus_ce_o, arb.mem_ack_o,
                 arb.if_ack_o, arb.err_o);
      end
    end
    set_data(1'b0, 32'h0000_0A00, 32'h0, 4'b1111);
    serve(1, 32'hCAFE_F00D, o);
    n_cmp++;
    if ({o.addr, o.ce_n, o.mem_ack, o.err, o.mem_rd} !==
        {32'h0000_0A00, 32'd2, 2'b10, 32'hCAFE_F00D}) begin
      n_bad++;
      $display("FAIL rst_mid_next: got addr=%h ce=%0d ack=%b err=%b rd=%h", o.addr, o.ce_n,
               o.mem_ack, o.err, o.mem_rd);
    end
    arb.mem_req_i = 1'b0;
    exp_last_data = 1'b1; exp_mem_rd = 32'hCAFE_F00D;
    @(negedge clk);
  endtask

  task automatic test_random(input int iters);
    obs_t o;
    bit pend_i, pend_m, g_data, tmo, mwe;
    logic [31:0] iaddr, maddr, mwdata, rd_i, rd_m, rd, exp_rd;
    logic [3:0] msel;
    int lat_i, lat_m, lat;
    logic [5:0] exp_busy, exp_done;
    for (int it = 0; it < iters; it++) begin
      pend_i = 1'($urandom_range(0, 1));
      pend_m = !pend_i || (1'($urandom_range(0, 1)));
      iaddr = $urandom & 32'hFFFF_FFFC; maddr = $urandom; mwdata = $urandom;
      msel = 4'($urandom); mwe = 1'($urandom); rd_i = $urandom; rd_m = $urandom;
      lat_i = $urandom_range(0, 19); lat_m = $urandom_range(0, 19);
      arb.if_req_i = pend_i; arb.if_addr_i = iaddr;
      arb.mem_req_i = pend_m; arb.mem_we_i = mwe; arb.mem_addr_i = maddr;
      arb.mem_wdata_i = mwdata; arb.mem_sel_i = msel;
      while (pend_i || pend_m) begin
        g_data = pend_m && (!pend_i || !exp_last_data);
        lat = g_data ? lat_m : lat_i;
        rd = g_data ? rd_m : rd_i;
        tmo = (lat >= int'(TO));
        exp_rd = (tmo || (g_data && mwe)) ? 32'h0 : rd;
        exp_busy = pend_m ? 6'b011111 : 6'b000111;
        exp_done = g_data ? (pend_i ? 6'b000111 : 6'b000000) : (pend_m ? 6'b011111 : 6'b000000);
        serve(lat, rd, o);
        n_cmp++;
        if ({o.wait_n, o.ce_n, o.stable, o.early} !== {32'd1, tmo ? int'(TO) : lat + 1, 2'b10})
        begin
          n_bad++;
          $display("FAIL rand%0d_timing: got wait=%0d ce=%0d stable=%b early=%b, want 1 %0d",
                   it, o.wait_n, o.ce_n, o.stable, o.early, tmo ? int'(TO) : lat + 1);
        end
        n_cmp++;
        if ({o.we, o.addr, o.sel, g_data ? o.wdata : mwdata} !==
            {g_data && mwe, g_data ? maddr : iaddr, g_data ? msel : 4'b1111, mwdata}) begin
          n_bad++;
          $display("FAIL rand%0d_grant: got we=%b addr=%h sel=%b, want data=%b", it, o.we,
                   o.addr, o.sel, g_data);
        end
        n_cmp++;
        if ({o.if_ack, o.mem_ack, o.err, g_data ? o.mem_rd : o.if_rd, o.stall_busy, o.stall_done}
            !== {!g_data, g_data, tmo, exp_rd, exp_busy, exp_done}) begin
          n_bad++;
          $display("FAIL rand%0d_resp: got ack=%b%b err=%b rd=%h stall=%b/%b, want %b%b %b %h",
                   it, o.if_ack, o.mem_ack, o.err, g_data ? o.mem_rd : o.if_rd, o.stall_busy,
                   o.stall_done, !g_data, g_data, tmo, exp_rd);
        end
        exp_last_data = g_data;
        if (g_data) begin
          exp_mem_rd = exp_rd; pend_m = 1'b0; arb.mem_req_i = 1'b0;
        end else begin
          exp_if_rd = exp_rd; pend_i = 1'b0; arb.if_req_i = 1'b0;
        end
      end
      @(negedge clk);
      n_cmp++;
      if ({arb.bus_ce_o, arb.if_ack_o, arb.mem_ack_o, arb.err_o, arb.if_rdata_o,
           arb.mem_rdata_o} !== {4'b0000, exp_if_rd, exp_mem_rd}) begin
        n_bad++;
        $display("FAIL rand%0d_hold: got ce=%b acks=%b%b err=%b rd=%h/%h", it, arb.bus_ce_o,
                 arb.if_ack_o, arb.mem_ack_o, arb.err_o, arb.if_rdata_o, arb.mem_rdata_o);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1;
    arb.if_req_i = 1'b0; arb.if_addr_i = 32'h0;
    arb.mem_req_i = 1'b0; arb.mem_we_i = 1'b0; arb.mem_addr_i = 32'h0;
    arb.mem_wdata_i = 32'h0; arb.mem_sel_i = 4'h0;
    arb.bus_rdata_i = 32'h0; arb.bus_ack_i = 1'b0;
    exp_last_data = 1'b0; exp_if_rd = 32'h0; exp_mem_rd = 32'h0;
    test_reset();
    test_idle_ack();
    test_fetch_only();
    test_simultaneous();
    test_slave_latency("slow_slave", 5, 32'h5555_AAAA);
    test_slave_latency("timeout", 1000, 32'h7777_7777);
    test_slave_latency("timeout_edge_ack", int'(TO) - 1, 32'h0BAD_F00D);
    test_reset_mid_xfer();
    test_random(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of bus cycles per transfer before abort (legal range 2..255).
REQ-002 SHALL have ports `clk` (in, 1) as the single clock and `rst` (in, 1); reset is asynchronous and active-high.
REQ-003 SHALL have instruction-side ports:
- `if_req_i` (in, 1): fetch request.
- `if_addr_i` (in, 32): fetch address.
- `if_ack_o` (out, 1): fetch done pulse.
- `if_rdata_o` (out, 32): fetched instruction.
REQ-004 SHALL have data-side ports:
- `mem_req_i` (in, 1): data request.
- `mem_we_i` (in, 1): write enable.
- `mem_addr_i` (in, 32): address.
- `mem_wdata_i` (in, 32): write data.
- `mem_sel_i` (in, 4): byte enables.
- `mem_ack_o` (out, 1): done pulse.
- `mem_rdata_o` (out, 32): read data.
REQ-005 SHALL have shared-bus ports:
- `bus_ce_o` (out, 1), `bus_we_o` (out, 1), `bus_addr_o` (out, 32), `bus_wdata_o` (out, 32), `bus_sel_o` (out, 4).
- `bus_rdata_i` (in, 32), `bus_ack_i` (in, 1).
REQ-006 SHALL have `stall_o` (out, 6), the pipeline stall vector: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb.
REQ-007 SHALL have `err_o` (out, 1), a one-cycle pulse on transfer timeout.

Function
REQ-008 SHALL implement FSM states IDLE, D_XFER and I_XFER.
REQ-009 In IDLE, at a clock edge, SHALL choose the next state as follows:
- mem_req_i=1 and if_req_i=0: D_XFER.
- if_req_i=1 and mem_req_i=0: I_XFER.
- both high: D_XFER, unless the previous completed grant was data, in which case I_XFER.
- neither high: stay in IDLE.
REQ-010 On entry to an XFER state, SHALL register the granted requester's address, we, wdata and sel into the bus outputs and hold them stable until the state exits.
- I_XFER drives bus_we_o=0 and bus_sel_o=4'b1111.
REQ-011 SHALL assert bus_ce_o=1 exactly while in D_XFER or I_XFER; in IDLE, bus_ce_o=0 and all other bus outputs are 0.
REQ-012 When bus_ack_i=1 at an edge in an XFER state, SHALL return to IDLE and, in the following cycle only:
- assert the granted requester's ack_o.
- drive that requester's rdata_o with the captured bus_rdata_i (32'h0 for data writes).
REQ-013 rdata_o outputs SHALL hold their last value between acks.
REQ-014 Minimum latency SHALL be: request sampled at edge N, bus_ce_o high in cycle N+1, and with bus_ack_i in that cycle, ack_o high in cycle N+2. A new grant may be sampled at the edge ending cycle N+2.
REQ-015 SHALL keep an 8-bit wait counter:
- cleared on XFER entry.
- incremented each XFER cycle without bus_ack_i.
REQ-016 If the counter equals TIMEOUT-1 and bus_ack_i=0 at an edge, SHALL:
- return to IDLE.
- in the next cycle, pulse the requester's ack_o with rdata_o=32'h0 and pulse err_o=1.
REQ-017 If bus_ack_i=1 on the timeout cycle, the ack SHALL win: normal completion, err_o=0.
REQ-018 If a requester drops its req mid-transfer, the transfer SHALL still complete and ack_o SHALL still pulse.
REQ-019 bus_ack_i=1 while in IDLE SHALL be ignored.
REQ-020 stall_o SHALL be combinational, by priority:
- 6'b011111 if mem_req_i=1 and mem_ack_o=0.
- else 6'b000111 if if_req_i=1 and if_ack_o=0.
- else 6'b000000.
REQ-021 The "last grant was data" flag SHALL update on every completion, including timeout.

Reset
REQ-022 While rst=1, SHALL force immediately (asynchronously):
- state=IDLE, counter=0, last-grant flag=instruction.
- all bus outputs, ack_o, rdata_o and err_o to 0.
REQ-023 Reset asserted mid-transfer SHALL drop bus_ce_o in the same cycle and produce no ack or err after release.
REQ-024 In the first edge after reset release, SHALL sample requests normally.

Verification
REQ-025 Bench SHALL cover these directed scenarios:
- Fetch only: if_req_i=1, if_addr_i=0x100, bus_ack_i high in the first bus cycle with bus_rdata_i=0x00000013 -> bus_ce_o one cycle, if_ack_o pulses 2 cycles after the request with if_rdata_o=0x00000013, stall_o=6'b000111 until the ack.
- Simultaneous requests, previous grant instruction: data write addr=0x200, wdata=0xDEADBEEF, sel=4'b1111 is granted first with bus_we_o=1; fetch follows; the next simultaneous pair grants the fetch first.
- Slow slave: bus_ack_i delayed 5 cycles -> bus outputs stable for 6 cycles, single ack pulse, err_o=0.
- Timeout with TIMEOUT=16 and no bus_ack_i -> exactly 16 cycles of bus_ce_o, then mem_ack_o=1, mem_rdata_o=0, err_o=1 for one cycle.
- Ack on the final timeout cycle -> normal read data, err_o=0.
- rst pulsed in the 3rd cycle of D_XFER -> bus_ce_o=0 immediately, no mem_ack_o after release, next request served normally.
